// File: rtl/hist_eq_frame_ctrl.sv
// Frame-level sequencer for histogram equalisation: ping-pongs the histogram
// and LUT banks, orders clear/accumulate/read-out/build/swap, flags overruns and timeouts.
module hist_eq_frame_ctrl #(
  parameter int TIMEOUT = 65535,
  parameter int FCNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              pre_img_vsync,
  input  logic              pre_img_valid,
  input  logic              hist_rd_done,
  input  logic              lut_write_ok,
  input  logic              err_clr,
  output logic              hist_clr,
  output logic              hist_rd_start,
  output logic              hist_bank,
  output logic              lut_bank_rd,
  output logic              eq_bypass,
  output logic              busy,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic [20:0]       pix_cnt_last,
  output logic              overrun_err,
  output logic              timeout_err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCUM   = 2'd1;
  localparam logic [1:0] S_READOUT = 2'd2;
  localparam logic [1:0] S_BUILD   = 2'd3;

  localparam int              TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic              vs_d_q;
  logic              hist_clr_q, hist_clr_d;
  logic              hist_rd_start_q, hist_rd_start_d;
  logic              hist_bank_q, hist_bank_d;
  logic              lut_bank_rd_q, lut_bank_rd_d;
  logic              eq_bypass_q, eq_bypass_d;
  logic              busy_q, busy_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [20:0]       pix_cnt_q, pix_cnt_d;
  logic [20:0]       pix_cnt_last_q, pix_cnt_last_d;
  logic              overrun_err_q, overrun_err_d;
  logic              timeout_err_q, timeout_err_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              vs_edge, ovr_set, to_set;

  function automatic logic [20:0] sat_inc(input logic [20:0] v);
    return (&v) ? v : v + 21'd1;
  endfunction

  assign vs_edge = pre_img_vsync & ~vs_d_q;

  always_comb begin
    state_d         = state_q;
    hist_clr_d      = 1'b0;
    hist_rd_start_d = 1'b0;
    hist_bank_d     = hist_bank_q;
    lut_bank_rd_d   = lut_bank_rd_q;
    eq_bypass_d     = eq_bypass_q;
    frame_cnt_d     = frame_cnt_q;
    pix_cnt_d       = pix_cnt_q;
    pix_cnt_last_d  = pix_cnt_last_q;
    to_cnt_d        = to_cnt_q;
    ovr_set         = 1'b0;
    to_set          = 1'b0;

    if (state_q != S_IDLE && pre_img_valid) pix_cnt_d = sat_inc(pix_cnt_q);

    case (state_q)
      S_IDLE: begin
        pix_cnt_d = '0;
        if (vs_edge && enable) begin
          hist_clr_d = 1'b1;
          state_d    = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (vs_edge) begin
          pix_cnt_last_d = pix_cnt_q;
          pix_cnt_d      = '0;
          if (enable) begin
            hist_bank_d     = ~hist_bank_q;
            hist_clr_d      = 1'b1;
            hist_rd_start_d = 1'b1;
            to_cnt_d        = '0;
            state_d         = S_READOUT;
          end else begin
            eq_bypass_d = 1'b1;
            state_d     = S_IDLE;
          end
        end
      end
      S_READOUT: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (hist_rd_done) begin
          to_cnt_d = '0;
          state_d  = S_BUILD;
        end else if (to_cnt_q == TO_LAST) begin
          to_set  = 1'b1;
          state_d = S_ACCUM;
        end
      end
      default: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (lut_write_ok) begin
          lut_bank_rd_d = ~lut_bank_rd_q;
          eq_bypass_d   = 1'b0;
          frame_cnt_d   = frame_cnt_q + FCNT_W'(1);
          state_d       = S_ACCUM;
        end else if (to_cnt_q == TO_LAST) begin
          to_set  = 1'b1;
          state_d = S_ACCUM;
        end
      end
    endcase

    // A frame edge during read-out/build drops that frame's statistics but keeps the work in flight.
    if (vs_edge && (state_q == S_READOUT || state_q == S_BUILD)) begin
      ovr_set    = 1'b1;
      hist_clr_d = 1'b1;
      pix_cnt_d  = '0;
    end

    overrun_err_d = ovr_set | (overrun_err_q & ~err_clr);
    timeout_err_d = to_set  | (timeout_err_q & ~err_clr);
    busy_d        = (state_d == S_READOUT) || (state_d == S_BUILD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      vs_d_q          <= 1'b0;
      hist_clr_q      <= 1'b0;
      hist_rd_start_q <= 1'b0;
      hist_bank_q     <= 1'b0;
      lut_bank_rd_q   <= 1'b0;
      eq_bypass_q     <= 1'b1;
      busy_q          <= 1'b0;
      frame_cnt_q     <= '0;
      pix_cnt_q       <= '0;
      pix_cnt_last_q  <= '0;
      overrun_err_q   <= 1'b0;
      timeout_err_q   <= 1'b0;
      to_cnt_q        <= '0;
    end else begin
      state_q         <= state_d;
      vs_d_q          <= pre_img_vsync;
      hist_clr_q      <= hist_clr_d;
      hist_rd_start_q <= hist_rd_start_d;
      hist_bank_q     <= hist_bank_d;
      lut_bank_rd_q   <= lut_bank_rd_d;
      eq_bypass_q     <= eq_bypass_d;
      busy_q          <= busy_d;
      frame_cnt_q     <= frame_cnt_d;
      pix_cnt_q       <= pix_cnt_d;
      pix_cnt_last_q  <= pix_cnt_last_d;
      overrun_err_q   <= overrun_err_d;
      timeout_err_q   <= timeout_err_d;
      to_cnt_q        <= to_cnt_d;
    end
  end

  assign hist_clr      = hist_clr_q;
  assign hist_rd_start = hist_rd_start_q;
  assign hist_bank     = hist_bank_q;
  assign lut_bank_rd   = lut_bank_rd_q;
  assign eq_bypass     = eq_bypass_q;
  assign busy          = busy_q;
  assign frame_cnt     = frame_cnt_q;
  assign pix_cnt_last  = pix_cnt_last_q;
  assign overrun_err   = overrun_err_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_hist_eq_frame_ctrl.sv
// Directed bench for hist_eq_frame_ctrl: frame sequencing, overrun, timeout,
// enable drop, error clearing and asynchronous reset.
module tb_hist_eq_frame_ctrl;
  localparam int FCNT_W = 16;

  logic              clk = 1'b0;
  logic              rst, enable, pre_img_vsync, pre_img_valid;
  logic              hist_rd_done, lut_write_ok, err_clr;
  logic              hist_clr, hist_rd_start, hist_bank, lut_bank_rd, eq_bypass, busy;
  logic [FCNT_W-1:0] frame_cnt;
  logic [20:0]       pix_cnt_last;
  logic              overrun_err, timeout_err;

  int checks = 0;
  int errors = 0;
  int n_clr = 0;
  int n_rd  = 0;

  hist_eq_frame_ctrl #(.TIMEOUT(1000), .FCNT_W(FCNT_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pre_img_vsync(pre_img_vsync),
    .pre_img_valid(pre_img_valid), .hist_rd_done(hist_rd_done),
    .lut_write_ok(lut_write_ok), .err_clr(err_clr), .hist_clr(hist_clr),
    .hist_rd_start(hist_rd_start), .hist_bank(hist_bank), .lut_bank_rd(lut_bank_rd),
    .eq_bypass(eq_bypass), .busy(busy), .frame_cnt(frame_cnt),
    .pix_cnt_last(pix_cnt_last), .overrun_err(overrun_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (hist_clr === 1'b1) n_clr++;
    if (hist_rd_start === 1'b1) n_rd++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic edge_start();
    pre_img_vsync = 1'b1;
    tick();
  endtask

  task automatic edge_end();
    tick();
    tick();
    pre_img_vsync = 1'b0;
    tick();
  endtask

  task automatic pixels(input int n);
    pre_img_valid = 1'b1;
    repeat (n) tick();
    pre_img_valid = 1'b0;
  endtask

  task automatic pulse_done();
    hist_rd_done = 1'b1;
    tick();
    hist_rd_done = 1'b0;
  endtask

  task automatic pulse_ok();
    lut_write_ok = 1'b1;
    tick();
    lut_write_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; pre_img_vsync = 1'b0; pre_img_valid = 1'b0;
    hist_rd_done = 1'b0; lut_write_ok = 1'b0; err_clr = 1'b0;
    tick(); tick();
    checks++; if (hist_bank !== 1'b0 || lut_bank_rd !== 1'b0 || eq_bypass !== 1'b1) begin errors++; $display("FAIL reset_banks got %b%b%b exp 001", hist_bank, lut_bank_rd, eq_bypass); end
    checks++; if (hist_clr !== 1'b0 || hist_rd_start !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b%b exp 000", hist_clr, hist_rd_start, busy); end
    checks++; if (frame_cnt !== 16'd0 || pix_cnt_last !== 21'd0 || overrun_err !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL reset_counts got %0d %0d %b%b exp 0 0 00", frame_cnt, pix_cnt_last, overrun_err, timeout_err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_normal_flow();
    int c0, r0;
    c0 = n_clr; r0 = n_rd;
    edge_start();
    checks++; if (hist_clr !== 1'b1 || hist_rd_start !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL nf_edge1 got clr=%b rd=%b busy=%b exp 1 0 0", hist_clr, hist_rd_start, busy); end
    edge_end();
    pixels(4800);
    edge_start();
    checks++; if (hist_rd_start !== 1'b1 || hist_clr !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL nf_edge2_pulses got rd=%b clr=%b busy=%b exp 1 1 1", hist_rd_start, hist_clr, busy); end
    checks++; if (pix_cnt_last !== 21'd4800 || hist_bank !== 1'b1) begin errors++; $display("FAIL nf_edge2_latch got %0d bank=%b exp 4800 bank=1", pix_cnt_last, hist_bank); end
    edge_end();
    repeat (297) tick();
    pulse_done();
    checks++; if (busy !== 1'b1 || lut_bank_rd !== 1'b0 || eq_bypass !== 1'b1) begin errors++; $display("FAIL nf_build got busy=%b lut=%b byp=%b exp 1 0 1", busy, lut_bank_rd, eq_bypass); end
    repeat (99) tick();
    pulse_ok();
    checks++; if (lut_bank_rd !== 1'b1 || eq_bypass !== 1'b0 || frame_cnt !== 16'd1 || busy !== 1'b0) begin errors++; $display("FAIL nf_swap1 got lut=%b byp=%b fc=%0d busy=%b exp 1 0 1 0", lut_bank_rd, eq_bypass, frame_cnt, busy); end
    pixels(1000);
    edge_start();
    checks++; if (pix_cnt_last !== 21'd1000 || hist_bank !== 1'b0) begin errors++; $display("FAIL nf_edge3 got %0d bank=%b exp 1000 bank=0", pix_cnt_last, hist_bank); end
    edge_end();
    repeat (297) tick();
    pulse_done();
    repeat (99) tick();
    pulse_ok();
    tick();
    checks++; if (frame_cnt !== 16'd2 || lut_bank_rd !== 1'b0 || hist_bank !== 1'b0) begin errors++; $display("FAIL nf_swap2 got fc=%0d lut=%b bank=%b exp 2 0 0", frame_cnt, lut_bank_rd, hist_bank); end
    checks++; if ((n_clr - c0) !== 3 || (n_rd - r0) !== 2) begin errors++; $display("FAIL nf_pulse_counts got clr=%0d rd=%0d exp 3 2", n_clr - c0, n_rd - r0); end
  endtask

  task automatic test_overrun();
    int c0, r0;
    pixels(50);
    c0 = n_clr; r0 = n_rd;
    edge_start();
    checks++; if (hist_bank !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL ov_edgeA got bank=%b busy=%b exp 1 1", hist_bank, busy); end
    edge_end();
    pixels(20);
    edge_start();
    checks++; if (overrun_err !== 1'b1 || hist_bank !== 1'b1 || hist_clr !== 1'b1 || hist_rd_start !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ov_edgeB got err=%b bank=%b clr=%b rd=%b busy=%b exp 1 1 1 0 1", overrun_err, hist_bank, hist_clr, hist_rd_start, busy); end
    edge_end();
    checks++; if ((n_clr - c0) !== 2 || (n_rd - r0) !== 1 || pix_cnt_last !== 21'd50) begin errors++; $display("FAIL ov_counts got clr=%0d rd=%0d last=%0d exp 2 1 50", n_clr - c0, n_rd - r0, pix_cnt_last); end
  endtask

  task automatic test_err_clr();
    int c0, r0;
    c0 = n_clr; r0 = n_rd;
    err_clr = 1'b1;
    edge_start();
    err_clr = 1'b0;
    checks++; if (overrun_err !== 1'b1) begin errors++; $display("FAIL ec_set_wins got %b exp 1", overrun_err); end
    edge_end();
    pixels(30);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL ec_clear got %b exp 0", overrun_err); end
    pulse_done();
    pulse_ok();
    tick();
    checks++; if (frame_cnt !== 16'd3 || lut_bank_rd !== 1'b1 || hist_bank !== 1'b1 || (n_clr - c0) !== 1 || (n_rd - r0) !== 0) begin errors++; $display("FAIL ec_finish got fc=%0d lut=%b bank=%b clr=%0d rd=%0d exp 3 1 1 1 0", frame_cnt, lut_bank_rd, hist_bank, n_clr - c0, n_rd - r0); end
  endtask

  task automatic test_timeout();
    int n;
    edge_start();
    checks++; if (pix_cnt_last !== 21'd30 || hist_bank !== 1'b0) begin errors++; $display("FAIL to_latch got %0d bank=%b exp 30 bank=0", pix_cnt_last, hist_bank); end
    edge_end();
    repeat (5) tick();
    pulse_done();
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      tick();
    end
    checks++; if (n !== 1000) begin errors++; $display("FAIL to_build_cycles got %0d exp 1000", n); end
    checks++; if (timeout_err !== 1'b1 || lut_bank_rd !== 1'b1 || eq_bypass !== 1'b0 || frame_cnt !== 16'd3) begin errors++; $display("FAIL to_flags got err=%b lut=%b byp=%b fc=%0d exp 1 1 0 3", timeout_err, lut_bank_rd, eq_bypass, frame_cnt); end
    pulse_ok();
    checks++; if (lut_bank_rd !== 1'b1 || frame_cnt !== 16'd3 || busy !== 1'b0) begin errors++; $display("FAIL to_ok_ignored got lut=%b fc=%0d busy=%b exp 1 3 0", lut_bank_rd, frame_cnt, busy); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear got %b exp 0", timeout_err); end
  endtask

  task automatic test_enable_drop();
    int r0;
    pixels(40);
    r0 = n_rd;
    enable = 1'b0;
    edge_start();
    checks++; if (busy !== 1'b0 || eq_bypass !== 1'b1 || hist_rd_start !== 1'b0 || hist_clr !== 1'b0) begin errors++; $display("FAIL ed_drop got busy=%b byp=%b rd=%b clr=%b exp 0 1 0 0", busy, eq_bypass, hist_rd_start, hist_clr); end
    checks++; if (pix_cnt_last !== 21'd40 || hist_bank !== 1'b0) begin errors++; $display("FAIL ed_latch got %0d bank=%b exp 40 bank=0", pix_cnt_last, hist_bank); end
    edge_end();
    pixels(10);
    edge_start();
    checks++; if (hist_clr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ed_idle_edge got clr=%b busy=%b exp 0 0", hist_clr, busy); end
    edge_end();
    enable = 1'b1;
    edge_start();
    checks++; if (hist_clr !== 1'b1 || hist_rd_start !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ed_reenable got clr=%b rd=%b busy=%b exp 1 0 0", hist_clr, hist_rd_start, busy); end
    edge_end();
    pixels(25);
    edge_start();
    checks++; if (pix_cnt_last !== 21'd25 || hist_bank !== 1'b1 || hist_rd_start !== 1'b1) begin errors++; $display("FAIL ed_resume got %0d bank=%b rd=%b exp 25 1 1", pix_cnt_last, hist_bank, hist_rd_start); end
    edge_end();
    checks++; if ((n_rd - r0) !== 1) begin errors++; $display("FAIL ed_rd_count got %0d exp 1", n_rd - r0); end
  endtask

  task automatic test_reset_mid();
    int c0;
    pulse_done();
    checks++; if (busy !== 1'b1 || lut_bank_rd !== 1'b1) begin errors++; $display("FAIL rm_pre got busy=%b lut=%b exp 1 1", busy, lut_bank_rd); end
    #3 rst = 1'b1;
    #1;
    checks++; if (lut_bank_rd !== 1'b0 || hist_bank !== 1'b0 || eq_bypass !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rm_async got lut=%b bank=%b byp=%b busy=%b exp 0 0 1 0", lut_bank_rd, hist_bank, eq_bypass, busy); end
    checks++; if (frame_cnt !== 16'd0 || pix_cnt_last !== 21'd0 || hist_clr !== 1'b0) begin errors++; $display("FAIL rm_async_cnt got fc=%0d last=%0d clr=%b exp 0 0 0", frame_cnt, pix_cnt_last, hist_clr); end
    tick(); tick();
    rst = 1'b0;
    c0 = n_clr;
    repeat (20) tick();
    checks++; if ((n_clr - c0) !== 0) begin errors++; $display("FAIL rm_no_clr got %0d exp 0", n_clr - c0); end
    edge_start();
    checks++; if (hist_clr !== 1'b1 || hist_rd_start !== 1'b0) begin errors++; $display("FAIL rm_restart got clr=%b rd=%b exp 1 0", hist_clr, hist_rd_start); end
    edge_end();
  endtask

  initial begin
    test_reset();
    test_normal_flow();
    test_overrun();
    test_err_clr();
    test_timeout();
    test_enable_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hist_eq_frame_ctrl.md
# hist_eq_frame_ctrl

Frame-level sequencer for the histogram-equalisation pipeline. It sits beside the histogram statistics and EQ-mapping datapaths on the pixel clock and watches the input frame sync. It ping-pongs the histogram accumulation bank and the equalisation LUT bank, and orders each frame's work: clear, accumulate, read-out, LUT build, swap. It also reports frame overruns and build timeouts.

## Interface
- TIMEOUT, 65535: max cycles allowed in READOUT or BUILD before abort.
- FCNT_W, 16: width of frame_cnt.
- clk  in  1  pixel clock; the block's only clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  run request; sampled only at a frame edge.
- pre_img_vsync  in  1  input frame sync, high during sync; a rising edge is the frame boundary.
- pre_img_valid  in  1  input pixel valid.
- hist_rd_done  in  1  pulse from the statistics block: all 256 bins of the read bank emitted.
- lut_write_ok  in  1  pulse from the EQ block: LUT write bank fully written.
- err_clr  in  1  pulse; clears the sticky error flags.
- hist_clr  out  1  1-cycle pulse; clear the accumulate bank.
- hist_rd_start  out  1  1-cycle pulse; start read-out of the non-accumulate bank.
- hist_bank  out  1  bank currently accumulating; the other bank is the read bank.
- lut_bank_rd  out  1  LUT bank used for mapping; the write bank is ~lut_bank_rd.
- eq_bypass  out  1  1 means pass pixels through unmapped (no valid LUT yet).
- busy  out  1  high in READOUT or BUILD.
- frame_cnt  out  FCNT_W  count of completed LUT swaps; wraps at 2^FCNT_W.
- pix_cnt_last  out  21  number of valid pixels in the last accumulated frame; saturates at 2^21-1.
- overrun_err  out  1  sticky: a frame edge arrived while in READOUT or BUILD.
- timeout_err  out  1  sticky: TIMEOUT expired.

## Operation
- Edge detect: vs_d is vsync registered; vs_edge = pre_img_vsync & ~vs_d. All actions below are registered on vs_edge.
- States: IDLE, ACCUM, READOUT, BUILD. The one-hot or encoded state is internal.
- IDLE: on vs_edge with enable=1, pulse hist_clr and go to ACCUM. With enable=0, stay in IDLE.
- ACCUM: pix_cnt increments on pre_img_valid.
  - On vs_edge with enable=1: latch pix_cnt into pix_cnt_last, zero pix_cnt, toggle hist_bank, pulse hist_clr and hist_rd_start, go to READOUT.
  - On vs_edge with enable=0: latch pix_cnt_last, set eq_bypass=1, go to IDLE.
- READOUT: hist_rd_done moves to BUILD and reloads the timeout counter.
- BUILD: lut_write_ok toggles lut_bank_rd, clears eq_bypass, increments frame_cnt, and returns to ACCUM.
- Overrun: vs_edge in READOUT or BUILD does the following:
  - sets overrun_err, pulses hist_clr, and zeroes pix_cnt;
  - leaves hist_bank unchanged and stays in the current state;
  - pixels of that frame are accumulated but never read out; enable is not sampled.
- Timeout: the counter is loaded with 0 on entry to READOUT and to BUILD, and increments each cycle. On reaching TIMEOUT-1, it sets timeout_err and goes to ACCUM. lut_bank_rd, eq_bypass and frame_cnt are unchanged.
- hist_rd_done or lut_write_ok arriving in any other state is ignored.
- pix_cnt counts only in ACCUM, READOUT and BUILD. It is held at 0 in IDLE.
- err_clr clears both sticky flags. If a new error condition occurs in the same cycle, the flag is set (set wins).

## Timing
- Reset values: state=IDLE, hist_bank=0, lut_bank_rd=0, eq_bypass=1. hist_clr, hist_rd_start, busy and both error flags are 0. frame_cnt=0, pix_cnt_last=0, and vs_d=0.
- vsync rising in cycle k (vs_edge true in k): pulses and the state change are visible in k+1. pix_cnt_last and hist_bank update in k+1.
- hist_rd_done or lut_write_ok sampled high in cycle k: the state, lut_bank_rd, eq_bypass and frame_cnt update in k+1.
- busy is a registered decode of state, so it follows the state with 0 extra latency.
- A vsync held high for many cycles produces exactly one vs_edge.
- rst asserted mid-frame forces all reset values immediately (asynchronous). Sequencing restarts at the next vs_edge after release.
- Minimum frame period for overrun-free operation: read-out cycles + build cycles + 1.

## Test plan
- Reset: assert rst in BUILD with lut_bank_rd=1 → all outputs at reset values before the next clk edge; no hist_clr pulse until a new vs_edge.
- Normal flow, 800x600, hist_rd_done 300 cycles after hist_rd_start, lut_write_ok 100 cycles later →
  - edge 1: hist_clr only;
  - edge 2: pix_cnt_last=480000, hist_bank=1, one hist_rd_start;
  - after lut_write_ok: lut_bank_rd=1, eq_bypass=0, frame_cnt=1;
  - 3 frames in total → frame_cnt=2, hist_bank=0.
- Overrun: withhold hist_rd_done across two frame edges → overrun_err=1, hist_bank unchanged, one hist_clr pulse per edge, and no second hist_rd_start.
- Timeout with TIMEOUT=1000: give hist_rd_done but no lut_write_ok → exactly 1000 cycles in BUILD, then ACCUM, timeout_err=1, lut_bank_rd and eq_bypass unchanged.
- Enable drop: enable=0 before an edge in ACCUM → IDLE, eq_bypass=1, no hist_rd_start. Re-enable → next edge pulses hist_clr only.
- err_clr in the same cycle as an overrun edge → overrun_err stays 1. A later err_clr alone → overrun_err=0.
